// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : serial_add_ctrl
//  Brief    : Bit-serial add/subtract controller driving one shared full adder,
//             LSB first, with a start/busy/done handshake.
//  Revision : 1.0  initial release
// ============================================================================

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             accept;
  logic             fa_sum;
  logic             fa_co;

  fulladder u_fa (
    .A   (opa_q[0]),
    .B   (opb_q[0]),
    .C   (carry_q),
    .sum (fa_sum),
    .co  (fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = start;
      end
      S_SHIFT: begin
        opa_d   = {1'b0, opa_q[WIDTH-1:1]};
        opb_d   = {1'b0, opb_q[WIDTH-1:1]};
        res_d   = {fa_sum, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          // carry_q here is the carry into the MSB; XOR with carry out gives signed overflow
          sum_d   = {fa_sum, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          ovf_d   = carry_q ^ fa_co;
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        accept  = start;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (accept) begin
      opa_d   = a;
      opb_d   = op_sub ? ~b : b;
      carry_d = op_sub ? 1'b1 : cin;
      cnt_d   = '0;
      state_d = S_SHIFT;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_FINISH);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

module fulladder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic sum,
  output logic co
);

  assign sum = A ^ B ^ C;
  assign co  = (A & B) | (C & (A ^ B));

endmodule

`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_add_ctrl
//  Brief    : Self-checking bench for serial_add_ctrl (WIDTH=8).
//  Revision : 1.0  initial release
// ============================================================================

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             op_sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_sub (op_sub),
    .a      (a),
    .b      (b),
    .cin    (cin),
    .busy   (busy),
    .done   (done),
    .sum    (sum),
    .cout   (cout),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns {ovf, cout, sum} from whole-word arithmetic.
  function automatic logic [WIDTH+1:0] ref_model(input logic [WIDTH-1:0] ra,
                                                 input logic [WIDTH-1:0] rb,
                                                 input logic rcin, input logic rsub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             v;
    bb   = rsub ? ~rb : rb;
    full = {1'b0, ra} + {1'b0, bb} + {{WIDTH{1'b0}}, (rsub ? 1'b1 : rcin)};
    v    = (ra[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
    return {v, full[WIDTH], full[WIDTH-1:0]};
  endfunction

  // Presents operands with start high and returns just after the accepting edge.
  task automatic do_start(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tcin, input logic tsub);
    a = ta; b = tb; cin = tcin; op_sub = tsub; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Edges until done is seen, or -1 if it never arrives.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int lat;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; op_sub = 1'b0;
    #3;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_init: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (sum !== 8'h96) begin
      errors++;
      $display("FAIL reset_preop: sum=%h want 96", sum);
    end
    @(posedge clk); #1;
    do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      errors++;
      $display("FAIL reset_midshift: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
               busy, done, sum, cout, ovf);
    end
    a = 8'h12; b = 8'h34; cin = 1'b0; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== WIDTH || sum !== 8'h46 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_recover: lat=%0d sum=%h cout=%b ovf=%b, want lat=%0d sum=46 cout=0 ovf=0",
               lat, sum, cout, ovf, WIDTH);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add;
    int lat;
    do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== WIDTH || sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL add_5A_3C: lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=96 cout=0 ovf=1",
               lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
    do_start(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== WIDTH || sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_FF_01: lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=00 cout=1 ovf=0",
               lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
    do_start(8'h00, 8'h00, 1'b1, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== WIDTH || sum !== 8'h01 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_cin: lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=01 cout=0 ovf=0",
               lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_sub;
    int lat;
    do_start(8'h10, 8'h20, 1'b1, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== WIDTH || sum !== 8'hF0 || cout !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_10_20: lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=F0 cout=0 ovf=0",
               lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
    do_start(8'h80, 8'h01, 1'b0, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== WIDTH || sum !== 8'h7F || cout !== 1'b1 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_80_01: lat=%0d sum=%h cout=%b ovf=%b, want lat=8 sum=7F cout=1 ovf=1",
               lat, sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_while_busy;
    int lat;
    int extra;
    do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat);
    checks++;
    if (lat + 3 !== WIDTH || sum !== 8'h96) begin
      errors++;
      $display("FAIL busy_ignore_result: lat=%0d sum=%h, want lat=8 sum=96", lat + 3, sum);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    checks++;
    if (extra !== 0 || sum !== 8'h96) begin
      errors++;
      $display("FAIL busy_ignore_noop: extra active cycles=%0d sum=%h, want 0 and 96", extra, sum);
    end
  endtask

  task automatic test_output_hold;
    int lat;
    int bad;
    do_start(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_done(lat);
    do_start(8'h5A, 8'h3C, 1'b0, 1'b0);
    bad = 0;
    for (int i = 1; i < WIDTH; i++) begin
      if (sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0 || done !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    if (sum !== 8'h00 || cout !== 1'b1 || ovf !== 1'b0 || done !== 1'b0) bad++;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL output_hold: %0d cycles changed early, want 0 (sum=%h cout=%b ovf=%b)",
               bad, sum, cout, ovf);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || sum !== 8'h96 || cout !== 1'b0 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL output_hold_second: done=%b sum=%h cout=%b ovf=%b, want 1 96 0 1",
               done, sum, cout, ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [WIDTH+1:0] exp;
    int bad;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 1000; k++) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      cin = 1'($urandom); op_sub = 1'($urandom);
      start = 1'b1;
      exp = ref_model(a, b, cin, op_sub);
      @(posedge clk); #1;
      bad = (busy !== 1'b1 || done !== 1'b0) ? 1 : 0;
      for (int i = 1; i < WIDTH; i++) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom);
        cin = 1'($urandom); op_sub = 1'($urandom);
        @(posedge clk); #1;
        if (busy !== 1'b1 || done !== 1'b0) bad++;
      end
      @(posedge clk); #1;
      checks++;
      if (bad !== 0 || done !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL b2b_timing[%0d]: bad=%0d done=%b busy=%b, want 0 1 0", k, bad, done, busy);
      end
      checks++;
      if ({ovf, cout, sum} !== exp) begin
        errors++;
        $display("FAIL b2b_result[%0d]: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                 k, ovf, cout, sum, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
      end
    end
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_start_while_busy();
    test_output_hold();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract controller. It time-shares one `fulladder` instance (ports A, B, C, sum, co) across WIDTH cycles to produce a WIDTH-bit result, least significant bit first.
- Sits between a requester, which uses a start/busy/done handshake, and the single-bit adder datapath.
- Owns operand shift registers, the carry flip-flop, the bit counter and the result/flag registers.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request pulse/level; sampled only when the block is idle
- op_sub  input  1  0 = add (a + b + cin), 1 = subtract (a - b)
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for add; ignored when op_sub=1
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when the result registers update
- sum  output  WIDTH  result, held until the next completion
- cout  output  1  carry out of the MSB; for subtract, 1 = no borrow
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset
  - Single clock domain.
  - rst_n low asynchronously forces: state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, bit counter=0, carry FF=0, shift registers=0.
  - Reset release is synchronous to clk; the first operation may start on the first edge after release.
- States
  - IDLE: busy=0, done=0. If start=1 at an edge, capture a, (op_sub ? ~b : b) and carry FF=(op_sub ? 1 : cin); clear the bit counter; go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - The fulladder sees A=opA[0], B=opB[0], C=carry FF.
    - Its sum bit shifts into the MSB of the internal result shift register; opA and opB shift right by one; carry FF<=co; counter increments.
    - When counter==WIDTH-1, also record the carry into the MSB (the current carry FF) for ovf, then go to FINISH.
  - FINISH: busy=0, done=1 for exactly one cycle.
    - sum, cout and ovf are loaded on the edge entering FINISH, so they are valid in the same cycle done is high.
    - If start=1 in FINISH, the operation is accepted exactly as in IDLE and the next state is SHIFT (back-to-back). Otherwise go to IDLE.
- Latency
  - start sampled at edge E0 → busy high from E0 to E_WIDTH → done high from E_WIDTH to E_WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- Handshake rules
  - start is ignored while busy=1; no queueing and no error flag.
  - Operands are sampled only on the accepting edge, so changes to a, b, op_sub or cin during SHIFT have no effect.
- Output stability
  - sum, cout and ovf change only on the edge entering FINISH (or on reset).
  - They keep the previous result throughout a subsequent SHIFT.
- Arithmetic
  - Modulo 2^WIDTH.
  - Subtract is two's complement: a + ~b + 1.
  - cout is the raw adder carry; no borrow inversion is applied.
- Reset mid-operation aborts immediately: no done pulse, outputs go to their reset values.

Test Plan:
- Reset: rst_n=0 mid-SHIFT (after 3 bits of 0x5A+0x3C) → busy, done, sum, cout and ovf go to 0 within the same cycle with no clock edge; after release with start=1, the block completes a fresh operation normally.
- Add, WIDTH=8: a=0x5A, b=0x3C, cin=0, op_sub=0 → done exactly 8 edges after the start edge; sum=0x96, cout=0, ovf=1. Then a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Then a=0x00, b=0x00, cin=1 → sum=0x01.
- Subtract: a=0x10, b=0x20, op_sub=1, cin=1 → sum=0xF0, cout=0, ovf=0 (cin ignored). a=0x80, b=0x01, op_sub=1 → sum=0x7F, cout=1, ovf=1.
- Start while busy: pulse start with a=0x01, b=0x01 two cycles into a 0x5A+0x3C operation → result 0x96 only, a single done pulse, and no second operation.
- Back-to-back: hold start=1 continuously with operands changing each accept → accepted in FINISH, done pulses every 9 cycles, and each result matches the operands present at its accepting edge. Across random a, b, cin, op_sub (≥1000 vectors), check against a reference model of {cout, sum} = a + (op_sub ? ~b : b) + (op_sub ? 1 : cin).
- Output hold: during a second operation's SHIFT, sum, cout and ovf stay at the first result until the second done.
